// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input, output strobe, shift-add multiplier and error flag
module alu_seq #(
  parameter int    WIDTH          = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 err,
  output logic [15:0]          leds
);
  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit PRIO_A = INPUT_PRIORITY == "A";
  localparam bit FA     = FULL_ADDER == "ON";
  localparam int W2     = 2 * WIDTH;
  typedef enum logic {IDLE, MUL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             cin;
    logic             sin;
    logic             dir;
    logic             ra;
    logic             rb;
    logic             ba;
    logic             bb;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d, out_q, out_d;
  logic            pend_q, pend_d, ov_q, ov_d, err_q, err_d;
  logic [15:0]     leds_q, leds_d;
  req_t            req_q, req_d;
  logic            accept, mul_go, inv, red_bit;
  logic [WIDTH-1:0] red_x, byp_x;
  logic [W2-1:0]   lgc, add, shf, rot, res, pp, acc_nx;

  function automatic logic is_inv(input logic [2:0] op, input logic red);
    return (&op[2:1]) || ((|op[2:1]) && red);
  endfunction

  assign req_d     = {A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};
  assign in_ready  = state_q == IDLE;
  assign accept    = in_valid && in_ready;
  assign mul_go    = opcode == 3'b011 && !is_inv(opcode, red_op_A || red_op_B) && !bypass_A && !bypass_B;
  assign out       = out_q;
  assign out_valid = ov_q;
  assign err       = err_q;
  assign leds      = leds_q;

  // Result of the pending single-cycle op and the next multiplier partial sum
  always_comb begin
    inv     = is_inv(req_q.op, req_q.ra || req_q.rb);
    red_x   = (req_q.ra && req_q.rb) ? (PRIO_A ? req_q.a : req_q.b) : req_q.ra ? req_q.a : req_q.b;
    red_bit = req_q.op[0] ? ^red_x : &red_x;
    byp_x   = (req_q.ba && req_q.bb) ? (PRIO_A ? req_q.a : req_q.b) : req_q.ba ? req_q.a : req_q.b;
    lgc     = (req_q.ra || req_q.rb) ? {{(W2-1){1'b0}}, red_bit}
            : {{WIDTH{1'b0}}, req_q.op[0] ? req_q.a ^ req_q.b : req_q.a & req_q.b};
    add     = {{WIDTH{1'b0}}, req_q.a} + {{WIDTH{1'b0}}, req_q.b} + {{(W2-1){1'b0}}, FA && req_q.cin};
    shf     = req_q.dir ? {out_q[W2-2:0], req_q.sin} : {req_q.sin, out_q[W2-1:1]};
    rot     = req_q.dir ? {out_q[W2-2:0], out_q[W2-1]} : {out_q[0], out_q[W2-1:1]};
    res     = (req_q.ba || req_q.bb) ? {{WIDTH{1'b0}}, byp_x} : inv ? '0
            : req_q.op[2] ? (req_q.op[0] ? rot : shf) : req_q.op[1] ? add : lgc;
    pp      = req_q.b[cnt_q] ? ({{WIDTH{1'b0}}, req_q.a} << cnt_q) : '0;
    acc_nx  = acc_q + pp;
  end

  // Next state: completions of pending ops, multiplier iterations and new accepts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    err_d   = err_q;
    leds_d  = leds_q;
    pend_d  = accept && !mul_go;
    if (pend_q) begin
      out_d  = res;
      ov_d   = 1'b1;
      err_d  = inv;
      leds_d = inv ? ~leds_q : '0;
    end
    if (state_q == MUL) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        out_d   = acc_nx;
        ov_d    = 1'b1;
        err_d   = 1'b0;
        leds_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
    if (accept && mul_go) begin
      state_d = MUL;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  // State registers; the request is captured at every accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      leds_q  <= '0;
      pend_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      leds_q  <= leds_d;
      pend_q  <= pend_d;
      if (accept) req_q <= req_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: two alu_seq instances (default and priority-B/no-carry) checked against a behavioural model
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [2:0] opcode = '0;
  logic cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
  logic red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
  logic rdy0, rdy1, ov0, ov1, err0, err1;
  logic [7:0] out0, out1;
  logic [15:0] leds0, leds1;
  int n_vec = 0, n_fail = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] op;
    logic cin, sin, dir, ra, rb, ba, bb;
  } req_t;

  logic [7:0]  m_out [2] = '{8'h00, 8'h00};
  logic [7:0]  m_mul_res = 8'h00;
  logic [15:0] m_leds = 16'h0;
  bit m_ov = 0, m_err = 0, m_rdy = 1, m_pend = 0, m_was = 1;
  int m_mul_left = 0;
  req_t m_req, m_new;

  alu_seq #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out0), .out_valid(ov0), .err(err0), .leds(leds0));

  alu_seq #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out1), .out_valid(ov1), .err(err1), .leds(leds1));

  always #5 clk = ~clk;

  function automatic bit model_inv(req_t r);
    return r.op >= 6 || (r.op >= 2 && (r.ra || r.rb));
  endfunction

  function automatic logic [7:0] model_res(req_t r, bit pa, bit fa, logic [7:0] cur);
    int a, b, c, x;
    a = int'(r.a); b = int'(r.b); c = int'(cur);
    if (r.ba && r.bb) return 8'(pa ? a : b);
    if (r.ba || r.bb) return 8'(r.ba ? a : b);
    if (model_inv(r)) return 8'h00;
    if (r.op <= 1) begin
      if (!(r.ra || r.rb)) return 8'(r.op == 0 ? a & b : a ^ b);
      x = (r.ra && r.rb) ? (pa ? a : b) : (r.ra ? a : b);
      return 8'(r.op == 0 ? int'(x == 15) : $countones(x) % 2);
    end
    if (r.op == 2) return 8'(a + b + (fa ? int'(r.cin) : 0));
    if (r.op == 4) return 8'(r.dir ? (c * 2) % 256 + int'(r.sin) : c / 2 + 128 * int'(r.sin));
    return 8'(r.dir ? (c * 2) % 256 + c / 128 : c / 2 + 128 * (c % 2));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = '{8'h00, 8'h00}; m_ov = 0; m_err = 0; m_leds = 16'h0; m_rdy = 1; m_pend = 0; m_mul_left = 0;
    end else begin
      m_was = m_rdy;
      m_ov = 0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_out = '{m_mul_res, m_mul_res}; m_ov = 1; m_err = 0; m_leds = 16'h0; m_rdy = 1;
        end
      end
      if (m_pend) begin
        for (int i = 0; i < 2; i++) m_out[i] = model_res(m_req, i == 0, i == 0, m_out[i]);
        m_ov = 1;
        m_err = model_inv(m_req);
        m_leds = m_err ? ~m_leds : 16'h0;
        m_pend = 0;
      end
      if (m_was && in_valid) begin
        m_new = '{A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};
        if (opcode == 3 && !model_inv(m_new) && !bypass_A && !bypass_B) begin
          m_mul_res = 8'(int'(A) * int'(B)); m_mul_left = 4; m_rdy = 0;
        end else begin
          m_req = m_new; m_pend = 1;
        end
      end
    end
  end

  task automatic cmp_dut(input int i, input logic [7:0] o, input logic v, e, input logic [15:0] l, input logic r);
    n_vec++;
    if ({o, v, e, l, r} !== {m_out[i], m_ov, m_err, m_leds, m_rdy}) begin
      n_fail++;
      $display("FAIL dut%0d t=%0t: out=%h valid=%b err=%b leds=%h ready=%b, expected out=%h valid=%b err=%b leds=%h ready=%b",
               i, $time, o, v, e, l, r, m_out[i], m_ov, m_err, m_leds, m_rdy);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      cmp_dut(0, out0, ov0, err0, leds0, rdy0);
      cmp_dut(1, out1, ov1, err1, leds1, rdy1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // flags = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [6:0] f);
    opcode = op; A = a; B = b;
    {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; chk_en = 1'b1;
    issue(3'd2, 4'hF, 4'h1, 7'b1000000); @(negedge clk);
    chk("add_pre", {out0, ov0}, {8'h11, 1'b1});
    #2 rst = 1'b0;
    #1 chk("reset_async", {out0, ov0, err0, leds0, rdy0, out1}, {8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h00});
    @(negedge clk) rst = 1'b1;
    issue(3'd2, 4'hF, 4'h1, 7'b1000000); @(negedge clk);
    chk("add_cin", {out0, ov0}, {8'h11, 1'b1});
    chk("add_nocarry", out1, 8'h10);
    issue(3'd3, 4'hF, 4'hF, 7'b0);
    chk("mul_busy0", rdy0, 1'b0);
    @(negedge clk); chk("mul_busy1", rdy0, 1'b0);
    opcode = 3'd2; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; chk("mul_busy2", rdy0, 1'b0);
    @(negedge clk); chk("mul_busy3", rdy0, 1'b0);
    @(negedge clk); chk("mul_done", {out0, ov0, rdy0, out1}, {8'hE1, 1'b1, 1'b1, 8'hE1});
    @(negedge clk); chk("mul_ignored", {out0, ov0}, {8'hE1, 1'b0});
    issue(3'd3, 4'hF, 4'hF, 7'b0);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("mul_reset", out0, 8'h00);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mul_abort", {out0, ov0, rdy0}, {8'h00, 1'b0, 1'b1});
    issue(3'd0, 4'h8, 4'h0, 7'b0000010); @(negedge clk);
    chk("bypass_a", out0, 8'h08);
    repeat (3) issue(3'd4, 4'h0, 4'h0, 7'b0010000);
    issue(3'd4, 4'h0, 4'h0, 7'b0110000); @(negedge clk);
    chk("chain_81", out0, 8'h81);
    issue(3'd5, 4'h0, 4'h0, 7'b0010000); @(negedge clk);
    chk("rot_left", out0, 8'h03);
    issue(3'd4, 4'h0, 4'h0, 7'b0100000); @(negedge clk);
    chk("shift_right", out0, 8'h81);
    issue(3'd4, 4'h0, 4'h0, 7'b0010000); @(negedge clk);
    chk("shift_left", out0, 8'h02);
    issue(3'd0, 4'hF, 4'h7, 7'b0001100); @(negedge clk);
    chk("red_and_prio_a", out0, 8'h01);
    chk("red_and_prio_b", out1, 8'h00);
    issue(3'd1, 4'h0, 4'h7, 7'b0000100); @(negedge clk);
    chk("red_xor_b", {out0, out1}, {8'h01, 8'h01});
    issue(3'd6, 4'h3, 4'h3, 7'b0); @(negedge clk);
    chk("inv_first", {err0, out0, leds0}, {1'b1, 8'h00, 16'hFFFF});
    issue(3'd6, 4'h3, 4'h3, 7'b0); @(negedge clk);
    chk("inv_second", {err0, out0, leds0}, {1'b1, 8'h00, 16'h0000});
    issue(3'd2, 4'h3, 4'h3, 7'b0001000); @(negedge clk);
    chk("inv_add_red", {err0, leds0}, {1'b1, 16'hFFFF});
    issue(3'd0, 4'h3, 4'h6, 7'b0); @(negedge clk);
    chk("valid_and", {err0, leds0, out0}, {1'b0, 16'h0000, 8'h02});
    issue(3'd0, 4'h3, 4'hC, 7'b0000011); @(negedge clk);
    chk("bypass_both", {out0, out1}, {8'h03, 8'h0C});
    for (int i = 0; i < 5; i++) begin
      issue(3'd2, 4'(i), 4'h1, 7'b0);
      if (i > 0) chk("b2b", {ov0, rdy0}, 2'b11);
    end
    @(negedge clk); chk("b2b_last", {ov0, out0}, {1'b1, 8'h05});
    for (int i = 0; i < 800; i++) begin
      A = 4'($urandom); B = 4'($urandom); opcode = 3'($urandom);
      cin = 1'($urandom); serial_in = 1'($urandom); direction = 1'($urandom);
      red_op_A = ($urandom % 5) == 0; red_op_B = ($urandom % 5) == 0;
      bypass_A = ($urandom % 6) == 0; bypass_B = ($urandom % 6) == 0;
      in_valid = ($urandom % 4) != 0;
      if (i % 250 == 249) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
